// File: rtl/edc_scrubber_if.sv
// Scrub port between the scrubber and the cache data/parity stores.
// Read side is combinational; the write side is a single-cycle strobe (err_dwe/err_pwe).
interface edc_scrubber_if #(
   parameter int ADDR_W = 9
);
   logic [ADDR_W-1:0] rd_addr;
   logic [31:0]       rd_data;
   logic [6:0]        rd_parity;
   logic              err_dwe;
   logic              err_pwe;
   logic [ADDR_W-1:0] err_addr;
   logic [31:0]       err_din;
   logic [6:0]        err_pin;

   modport master (
      output rd_addr,
      input  rd_data,
      input  rd_parity,
      output err_dwe,
      output err_pwe,
      output err_addr,
      output err_din,
      output err_pin
   );

   modport slave (
      input  rd_addr,
      output rd_data,
      output rd_parity,
      input  err_dwe,
      input  err_pwe,
      input  err_addr,
      input  err_din,
      input  err_pin
   );
endinterface

// File: rtl/edc_scrubber.sv
// Background SEC-DED scrubber: walks the cache data store, checks Hamming(38,32)+parity,
// writes corrections back and keeps corrected/uncorrectable error statistics.
module edc_scrubber #(
   parameter int DEPTH    = 512,
   parameter int ADDR_W   = 9,
   parameter int INTERVAL = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scrub_en,
   input  logic              cache_idle,
   edc_scrubber_if.master    bus,
   output logic              sweep_done,
   output logic [15:0]       corr_cnt,
   output logic [15:0]       uncorr_cnt,
   output logic              uncorr_flag,
   output logic [ADDR_W-1:0] uncorr_addr,
   output logic [2:0]        dbg_state
);

   localparam int WCNT_W = (INTERVAL > 0) ? $clog2(INTERVAL + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_CHECK = 3'd2,
      S_FIX   = 3'd3,
      S_WAIT  = 3'd4
   } state_t;

   // Check bits p[5:0]: data bits sit at the non-power-of-two positions 3..38.
   function automatic logic [5:0] calc_chk(input logic [31:0] d);
      logic [5:0] p;
      logic [5:0] pos;
      int         k;
      p = '0;
      k = 0;
      for (int n = 1; n <= 38; n++) begin
         pos = 6'(n);
         if ((pos & (pos - 6'd1)) != 6'd0) begin
            for (int i = 0; i < 6; i++) begin
               if (pos[i]) p[i] = p[i] ^ d[k];
            end
            k++;
         end
      end
      return p;
   endfunction

   // Flips the data bit living at codeword position s; no-op for check-bit positions.
   function automatic logic [31:0] flip_pos(input logic [31:0] d, input logic [5:0] s);
      logic [31:0] r;
      logic [5:0]  pos;
      int          k;
      r = d;
      k = 0;
      for (int n = 1; n <= 38; n++) begin
         pos = 6'(n);
         if ((pos & (pos - 6'd1)) != 6'd0) begin
            if (pos == s) r[k] = ~r[k];
            k++;
         end
      end
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [31:0]         word_d_q, word_d_d;
   logic [6:0]          word_p_q, word_p_d;
   logic [15:0]         corr_cnt_q, corr_cnt_d;
   logic [15:0]         uncorr_cnt_q, uncorr_cnt_d;
   logic                uncorr_flag_q, uncorr_flag_d;
   logic [ADDR_W-1:0]   uncorr_addr_q, uncorr_addr_d;

   logic [5:0]  syn;
   logic        ov;
   logic        fixable;
   logic        uncorr;
   logic [31:0] fixed_d;
   logic [5:0]  fixed_chk;
   logic [6:0]  fixed_p;

   assign syn       = calc_chk(word_d_q) ^ word_p_q[5:0];
   assign ov        = (^word_d_q) ^ (^word_p_q);
   assign fixable   = ov && (syn <= 6'd38);
   assign uncorr    = (ov && (syn > 6'd38)) || (!ov && (syn != 6'd0));
   assign fixed_d   = flip_pos(word_d_q, syn);
   assign fixed_chk = calc_chk(fixed_d);
   assign fixed_p   = {(^fixed_d) ^ (^fixed_chk), fixed_chk};

   // cache_idle is the grant: a read is captured, or a write is issued, only in a
   // cycle where it is high; otherwise the FSM holds (ISSUE) or re-reads (FIX).
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      wait_cnt_d    = wait_cnt_q;
      word_d_d      = word_d_q;
      word_p_d      = word_p_q;
      corr_cnt_d    = corr_cnt_q;
      uncorr_cnt_d  = uncorr_cnt_q;
      uncorr_flag_d = uncorr_flag_q;
      uncorr_addr_d = uncorr_addr_q;
      sweep_done    = 1'b0;
      bus.err_dwe   = 1'b0;
      bus.err_pwe   = 1'b0;
      bus.err_addr  = '0;
      bus.err_din   = '0;
      bus.err_pin   = '0;

      case (state_q)
         S_IDLE: begin
            if (scrub_en) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (cache_idle) begin
               word_d_d = bus.rd_data;
               word_p_d = bus.rd_parity;
               state_d  = S_CHECK;
            end
         end
         S_CHECK: begin
            if (fixable) begin
               word_d_d = fixed_d;
               word_p_d = fixed_p;
               state_d  = S_FIX;
            end else begin
               if (uncorr) begin
                  if (uncorr_cnt_q != 16'hFFFF) uncorr_cnt_d = uncorr_cnt_q + 16'd1;
                  uncorr_flag_d = 1'b1;
                  uncorr_addr_d = ptr_q;
               end
               wait_cnt_d = '0;
               state_d    = S_WAIT;
            end
         end
         S_FIX: begin
            if (cache_idle) begin
               bus.err_dwe  = 1'b1;
               bus.err_pwe  = 1'b1;
               bus.err_addr = ptr_q;
               bus.err_din  = word_d_q;
               bus.err_pin  = word_p_q;
               if (corr_cnt_q != 16'hFFFF) corr_cnt_d = corr_cnt_q + 16'd1;
               wait_cnt_d = '0;
               state_d    = S_WAIT;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_WAIT: begin
            if (wait_cnt_q == WCNT_W'(INTERVAL)) begin
               if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                  ptr_d      = '0;
                  sweep_done = 1'b1;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
               state_d = scrub_en ? S_ISSUE : S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         wait_cnt_q    <= '0;
         word_d_q      <= '0;
         word_p_q      <= '0;
         corr_cnt_q    <= '0;
         uncorr_cnt_q  <= '0;
         uncorr_flag_q <= 1'b0;
         uncorr_addr_q <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         wait_cnt_q    <= wait_cnt_d;
         word_d_q      <= word_d_d;
         word_p_q      <= word_p_d;
         corr_cnt_q    <= corr_cnt_d;
         uncorr_cnt_q  <= uncorr_cnt_d;
         uncorr_flag_q <= uncorr_flag_d;
         uncorr_addr_q <= uncorr_addr_d;
      end
   end

   assign bus.rd_addr = ptr_q;
   assign corr_cnt    = corr_cnt_q;
   assign uncorr_cnt  = uncorr_cnt_q;
   assign uncorr_flag = uncorr_flag_q;
   assign uncorr_addr = uncorr_addr_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_edc_scrubber.sv
// Directed bench for edc_scrubber: behavioural cache store, write scoreboard and
// hand-built error vectors (single-bit data, p[6], double-bit) plus stall/reset cases.
module tb_edc_scrubber;

   localparam int ADDR_W  = 9;
   localparam int DEPTH   = 512;
   localparam int PKT_W   = ADDR_W + 32 + 7;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_CHECK = 3'd2;
   localparam logic [2:0] ST_FIX   = 3'd3;

   logic              clk = 1'b0;
   logic              rst;
   logic              scrub_en;
   logic              cache_idle;
   logic              sweep_done;
   logic [15:0]       corr_cnt;
   logic [15:0]       uncorr_cnt;
   logic              uncorr_flag;
   logic [ADDR_W-1:0] uncorr_addr;
   logic [2:0]        dbg_state;

   logic [31:0] mem_d [DEPTH];
   logic [6:0]  mem_p [DEPTH];
   logic [PKT_W-1:0] exp_q[$];
   int vec_cnt  = 0;
   int miss_cnt = 0;
   int wr_cnt   = 0;
   int done_cnt = 0;

   edc_scrubber_if #(.ADDR_W(ADDR_W)) bus ();

   edc_scrubber #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INTERVAL(0)) dut (
      .clk         (clk),
      .rst         (rst),
      .scrub_en    (scrub_en),
      .cache_idle  (cache_idle),
      .bus         (bus),
      .sweep_done  (sweep_done),
      .corr_cnt    (corr_cnt),
      .uncorr_cnt  (uncorr_cnt),
      .uncorr_flag (uncorr_flag),
      .uncorr_addr (uncorr_addr),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // cache store model
   assign bus.rd_data   = mem_d[bus.rd_addr];
   assign bus.rd_parity = mem_p[bus.rd_addr];
   always @(posedge clk) begin
      if (bus.err_dwe) mem_d[bus.err_addr] <= bus.err_din;
      if (bus.err_pwe) mem_p[bus.err_addr] <= bus.err_pin;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference encoder: check bits are the XOR of the positions of all set data bits.
   function automatic logic [6:0] ref_enc(input logic [31:0] d);
      logic [5:0] syn;
      int k;
      syn = '0;
      k = 0;
      for (int pos = 3; pos <= 38; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (d[k]) syn = syn ^ 6'(pos);
            k++;
         end
      end
      return {(^d) ^ (^syn), syn};
   endfunction

   // write scoreboard / sweep_done monitor
   always @(negedge clk) begin
      #1;
      if (sweep_done) done_cnt++;
      if (bus.err_dwe || bus.err_pwe) begin
         chk("pwe_eq_dwe", {63'd0, bus.err_pwe}, {63'd0, bus.err_dwe});
         wr_cnt++;
         chk("wr_expected", {63'd0, exp_q.size() != 0}, 64'd1);
         if (exp_q.size() != 0)
            chk("wr_pkt", {16'd0, bus.err_addr, bus.err_din, bus.err_pin}, {16'd0, exp_q.pop_front()});
      end
   end

   task automatic run_sweep(input string tag, input int limit, output int cycles);
      cycles = 0;
      scrub_en = 1'b1;
      do begin
         @(negedge clk);
         cycles++;
      end while (!sweep_done && cycles < limit);
      chk({tag, "_done_seen"}, {63'd0, sweep_done}, 64'd1);
      scrub_en = 1'b0;
      @(negedge clk);
   endtask

   int n;
   logic [6:0] enc_v;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = '0;
         mem_p[i] = '0;
      end
      rst = 1'b1;
      scrub_en = 1'b0;
      cache_idle = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      chk("rst_dwe", 64'(bus.err_dwe), 64'd0);
      chk("rst_cnts", {32'd0, corr_cnt, uncorr_cnt}, 64'd0);
      chk("rst_flag", 64'(uncorr_flag), 64'd0);
      rst = 1'b0;

      // clean sweep: 3 cycles per entry
      run_sweep("clean", 2000, n);
      chk("clean_cycles", 64'(n), 64'd1536);
      chk("clean_done_cnt", 64'(done_cnt), 64'd1);
      chk("clean_writes", 64'(wr_cnt), 64'd0);
      chk("clean_cnts", {32'd0, corr_cnt, uncorr_cnt}, 64'd0);
      chk("clean_idle_ptr", {61'd0, dbg_state} | (64'(bus.rd_addr) << 8), 64'(ST_IDLE));

      // single data bit, p[6] flip, double data bit
      enc_v = ref_enc(32'hDEADBEEF);
      mem_d[5] = 32'hDEADBEEE;
      mem_p[5] = enc_v;
      exp_q.push_back({9'd5, 32'hDEADBEEF, enc_v});
      enc_v = ref_enc(32'h12345678);
      mem_d[7] = 32'h12345678;
      mem_p[7] = enc_v ^ 7'h40;
      exp_q.push_back({9'd7, 32'h12345678, enc_v});
      mem_d[9] = 32'h0000_0003;
      mem_p[9] = 7'h00;
      run_sweep("err", 3000, n);
      chk("err_writes", 64'(wr_cnt), 64'd2);
      chk("err_corr_cnt", 64'(corr_cnt), 64'd2);
      chk("err_uncorr_cnt", 64'(uncorr_cnt), 64'd1);
      chk("err_uncorr_flag", 64'(uncorr_flag), 64'd1);
      chk("err_uncorr_addr", 64'(uncorr_addr), 64'd9);
      chk("err_mem5", 64'(mem_d[5]), 64'h0000_0000_DEAD_BEEF);
      chk("err_mem7_p", 64'(mem_p[7]), 64'(ref_enc(32'h12345678)));

      // clean sweep after repairing word 9: flag is sticky
      mem_d[9] = '0;
      run_sweep("sticky", 2000, n);
      chk("sticky_writes", 64'(wr_cnt), 64'd2);
      chk("sticky_flag", 64'(uncorr_flag), 64'd1);
      chk("sticky_uncorr_cnt", 64'(uncorr_cnt), 64'd1);
      chk("sticky_done_cnt", 64'(done_cnt), 64'd3);

      // ISSUE stall, then FIX abandoned when the cache goes busy
      mem_d[2] = 32'h0000_0020;
      exp_q.push_back({9'd2, 32'h0, 7'h0});
      cache_idle = 1'b0;
      scrub_en = 1'b1;
      repeat (11) @(negedge clk);
      chk("stall_rd_addr", 64'(bus.rd_addr), 64'd0);
      chk("stall_state", 64'(dbg_state), 64'(ST_ISSUE));
      cache_idle = 1'b1;
      n = 0;
      while (dbg_state != ST_FIX && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("fix_reached", 64'(dbg_state), 64'(ST_FIX));
      cache_idle = 1'b0;
      @(negedge clk);
      chk("fixdrop_state", 64'(dbg_state), 64'(ST_ISSUE));
      chk("fixdrop_rd_addr", 64'(bus.rd_addr), 64'd2);
      chk("fixdrop_writes", 64'(wr_cnt), 64'd2);
      repeat (2) @(negedge clk);
      cache_idle = 1'b1;
      n = 0;
      while (wr_cnt == 2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("refix_writes", 64'(wr_cnt), 64'd3);
      chk("refix_corr_cnt", 64'(corr_cnt), 64'd3);

      // scrub_en dropped while checking entry 100
      n = 0;
      while (!(bus.rd_addr == 9'd100 && dbg_state == ST_CHECK) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("at_100_check", 64'(bus.rd_addr), 64'd100);
      scrub_en = 1'b0;
      n = 0;
      while (dbg_state != ST_IDLE && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("stop_state", 64'(dbg_state), 64'(ST_IDLE));
      chk("stop_ptr", 64'(bus.rd_addr), 64'd101);

      // reset during the FIX write cycle
      mem_d[110] = 32'h8000_0000;
      exp_q.push_back({9'd110, 32'h0, 7'h0});
      scrub_en = 1'b1;
      n = 0;
      while (dbg_state != ST_FIX && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rstfix_addr", 64'(bus.rd_addr), 64'd110);
      rst = 1'b1;
      @(negedge clk);
      chk("rstfix_dwe", 64'(bus.err_dwe), 64'd0);
      chk("rstfix_ptr", 64'(bus.rd_addr), 64'd0);
      chk("rstfix_cnts", {32'd0, corr_cnt, uncorr_cnt}, 64'd0);
      chk("rstfix_flag", 64'(uncorr_flag), 64'd0);
      chk("rstfix_state", 64'(dbg_state), 64'(ST_IDLE));
      rst = 1'b0;
      scrub_en = 1'b0;
      repeat (2) @(negedge clk);
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
